// File: rtl/cpu_pkg.sv
// Shared definitions for the vector engine: operation codes, FSM state
// encoding and default address/data widths.
package cpu_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned DW_DEF = 8;

  // Element-wise operation selector.
  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_AND  = 2'b10,
    OP_COPY = 2'b11
  } vec_op_e;

  // Engine sequencing states; one RAM access per state.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } vec_state_e;

endpackage : cpu_pkg

// File: rtl/vec_alu.sv
// Combinational element operator: res = f(opa, opb), all results wrap
// modulo 2^DW with no carry/borrow reported.
module vec_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [1:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic [DW-1:0] res
);

  // Select the element operation; the default arm keeps an all-zero result.
  always_comb begin
    res = {DW{1'b0}};
    case (op)
      OP_ADD:  res = opa + opb;
      OP_SUB:  res = opa - opb;
      OP_AND:  res = opa & opb;
      OP_COPY: res = opa;
      default: res = {DW{1'b0}};
    endcase
  end

endmodule : vec_alu

// File: rtl/mem_vec_engine.sv
// Vector engine in front of a single-port RAM. While running it owns the
// RAM port and streams dst[i] = f(a[i], b[i]) one element at a time
// (read A, read B, write result). When idle the CPU port is forwarded
// straight through to the RAM.
module mem_vec_engine
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  input  logic          cpu_mem_enable,
  input  logic [AW-1:0] cpu_adress,
  input  logic [DW-1:0] cpu_din,
  output logic          mem_enable,
  output logic [AW-1:0] adress,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout_ram
);

  vec_state_e    state_q;
  logic [1:0]    op_q;
  logic [AW-1:0] src_a_q;
  logic [AW-1:0] src_b_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] i_q;
  logic [DW-1:0] opa_q;
  logic [DW-1:0] res_q;

  logic [DW-1:0] alu_res_s;
  logic [AW:0]   i_next_s;

  // One extra bit so the "more elements left" compare cannot wrap.
  assign i_next_s = {1'b0, i_q} + {{AW{1'b0}}, 1'b1};

  vec_alu #(
    .DW (DW)
  ) u_alu (
    .op  (op_q),
    .opa (opa_q),
    .opb (dout_ram),
    .res (alu_res_s)
  );

  // Sequencer: launch capture, per-element read/read/write walk, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      src_a_q <= {AW{1'b0}};
      src_b_q <= {AW{1'b0}};
      dst_q   <= {AW{1'b0}};
      len_q   <= {AW{1'b0}};
      i_q     <= {AW{1'b0}};
      opa_q   <= {DW{1'b0}};
      res_q   <= {DW{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            len_q   <= len;
            i_q     <= {AW{1'b0}};
            if (len == {AW{1'b0}}) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RD_A;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_A: begin
          opa_q   <= dout_ram;
          state_q <= ST_RD_B;
        end
        ST_RD_B: begin
          res_q   <= alu_res_s;
          state_q <= ST_WR;
        end
        ST_WR: begin
          i_q <= i_next_s[AW-1:0];
          if (i_next_s < {1'b0, len_q}) begin
            state_q <= ST_RD_A;
          end else begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status flags decode directly from the state register (no extra logic depth).
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // RAM port mux: CPU pass-through when idle, engine addressing otherwise.
  // CPU writes are dropped whenever the engine owns the port.
  always_comb begin
    mem_enable = 1'b0;
    adress     = {AW{1'b0}};
    din        = {DW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        mem_enable = cpu_mem_enable;
        adress     = cpu_adress;
        din        = cpu_din;
      end
      ST_RD_A: begin
        adress = src_a_q + i_q;
      end
      ST_RD_B: begin
        adress = src_b_q + i_q;
      end
      ST_WR: begin
        adress     = dst_q + i_q;
        din        = res_q;
        mem_enable = 1'b1;
      end
      ST_DONE: begin
        adress = dst_q;
      end
      default: begin
        mem_enable = 1'b0;
        adress     = {AW{1'b0}};
        din        = {DW{1'b0}};
      end
    endcase
  end

endmodule : mem_vec_engine

// File: tb/tb_mem_vec_engine.sv
// Directed bench: engine plus a 256x8 RAM with combinational read.
module tb_mem_vec_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [7:0] src_a;
  logic [7:0] src_b;
  logic [7:0] dst;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic       cpu_mem_enable;
  logic [7:0] cpu_adress;
  logic [7:0] cpu_din;
  logic       mem_enable;
  logic [7:0] adress;
  logic [7:0] din;
  logic [7:0] dout_ram;

  logic [7:0] mem [256];

  int checks;
  int failures;

  mem_vec_engine #(.AW(8), .DW(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .op             (op),
    .src_a          (src_a),
    .src_b          (src_b),
    .dst            (dst),
    .len            (len),
    .busy           (busy),
    .done           (done),
    .cpu_mem_enable (cpu_mem_enable),
    .cpu_adress     (cpu_adress),
    .cpu_din        (cpu_din),
    .mem_enable     (mem_enable),
    .adress         (adress),
    .din            (din),
    .dout_ram       (dout_ram)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  assign dout_ram = mem[adress];
  always @(posedge clk) begin
    if (mem_enable) mem[adress] <= din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_mem_enable = 1'b1;
    cpu_adress     = a;
    cpu_din        = d;
    @(negedge clk);
    cpu_mem_enable = 1'b0;
  endtask

  // Start pulse at one negedge, inputs scrambled at the next (after capture).
  task automatic launch(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] d, input logic [7:0] l);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dst = d; len = l;
    @(negedge clk);
    start = 1'b0; op = 2'b10; src_a = 8'h33; src_b = 8'h44; dst = 8'h55; len = 8'h09;
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] d, input logic [7:0] l,
                     input bit disturb);
    int cyc;
    int dcnt;
    int dat;
    int wcnt;
    int exp_busy;
    cyc = 0; dcnt = 0; dat = 0; wcnt = 0;
    exp_busy = (l == 8'd0) ? 1 : 3 * int'(l) + 1;
    launch(o, a, b, d, l);
    while (busy && cyc < 1000) begin
      cyc++;
      if (done) begin dcnt++; dat = cyc; end
      if (mem_enable) wcnt++;
      if (disturb) begin
        case (cyc)
          2: begin cpu_mem_enable = 1'b1; cpu_adress = 8'h20; cpu_din = 8'h55; end
          3: begin start = 1'b1; op = 2'b11; src_a = 8'h0A; dst = 8'h60; len = 8'h01; end
          4: begin cpu_mem_enable = 1'b0; start = 1'b0; end
          default: ;
        endcase
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, exp_busy);
    check({tag, "_done_count"}, dcnt, 1);
    check({tag, "_done_last"}, dat, exp_busy);
    check({tag, "_writes"}, wcnt, int'(l));
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    src_a = 8'h00; src_b = 8'h00; dst = 8'h00; len = 8'h00;
    cpu_mem_enable = 1'b0; cpu_adress = 8'h33; cpu_din = 8'h00;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_adress_fwd", adress, 8'h33);
    @(negedge clk);
    rst_n = 1'b1;

    // Clear and preload RAM through the idle pass-through path
    for (int k = 0; k < 256; k++) cpu_write(8'(k), 8'h00);
    for (int k = 0; k < 5; k++) cpu_write(8'h0A + 8'(k), 8'(k + 2));
    for (int k = 0; k < 5; k++) cpu_write(8'h80 + 8'(k), 8'(k + 1));
    cpu_write(8'h02, 8'h77);
    check("preload_0C", mem[8'h0C], 8'h04);
    check("preload_84", mem[8'h84], 8'h05);

    // Reset in RD_A of element 2 of ADD 0x0A+0x80 -> 0x40
    launch(2'b00, 8'h0A, 8'h80, 8'h40, 8'h05);
    repeat (6) @(negedge clk);
    check("rstmid_rda_addr", adress, 8'h0C);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_memen", mem_enable, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid_40", mem[8'h40], 8'd3);
    check("rstmid_41", mem[8'h41], 8'd5);
    check("rstmid_42", mem[8'h42], 8'd0);
    check("rstmid_43", mem[8'h43], 8'd0);
    check("rstmid_44", mem[8'h44], 8'd0);

    // Full ADD with ignored start and dropped CPU write while busy
    run("add", 2'b00, 8'h0A, 8'h80, 8'h40, 8'h05, 1'b1);
    check("add_40", mem[8'h40], 8'd3);
    check("add_41", mem[8'h41], 8'd5);
    check("add_42", mem[8'h42], 8'd7);
    check("add_43", mem[8'h43], 8'd9);
    check("add_44", mem[8'h44], 8'd11);
    check("busy_cpu_write_dropped", mem[8'h20], 8'h00);
    check("busy_start_ignored", mem[8'h60], 8'h00);
    check("idle_after_add", busy, 1'b0);

    // SUB a-b and reversed (wraps to 0xFF)
    run("sub", 2'b01, 8'h0A, 8'h80, 8'h50, 8'h05, 1'b0);
    for (int k = 0; k < 5; k++) check("sub_elem", mem[8'h50 + 8'(k)], 8'd1);
    run("subrev", 2'b01, 8'h80, 8'h0A, 8'h58, 8'h05, 1'b0);
    for (int k = 0; k < 5; k++) check("subrev_elem", mem[8'h58 + 8'(k)], 8'hFF);

    // COPY with destination address wrap
    run("copy", 2'b11, 8'h0A, 8'h80, 8'hFE, 8'h04, 1'b0);
    check("copy_FE", mem[8'hFE], 8'd2);
    check("copy_FF", mem[8'hFF], 8'd3);
    check("copy_00", mem[8'h00], 8'd4);
    check("copy_01", mem[8'h01], 8'd5);
    check("copy_02_untouched", mem[8'h02], 8'h77);

    // len = 0
    run("len0", 2'b00, 8'h0A, 8'h80, 8'h70, 8'h00, 1'b0);
    check("len0_no_write", mem[8'h70], 8'h00);

    // In-place ADD on 0x80..0x84
    run("inplace", 2'b00, 8'h80, 8'h80, 8'h80, 8'h05, 1'b0);
    for (int k = 0; k < 5; k++) check("inplace_elem", mem[8'h80 + 8'(k)], 8'(2 * (k + 1)));

    // Idle pass-through
    @(negedge clk);
    cpu_mem_enable = 1'b1; cpu_adress = 8'h10; cpu_din = 8'hAA;
    #1;
    check("pass_memen", mem_enable, 1'b1);
    check("pass_adress", adress, 8'h10);
    check("pass_din", din, 8'hAA);
    @(negedge clk);
    cpu_mem_enable = 1'b0;
    check("pass_ram", mem[8'h10], 8'hAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_vec_engine

// File: doc/mem_vec_engine.md
# mem_vec_engine

Vector engine sitting directly upstream of the 256×8 data RAM. It owns the RAM port while running. Given two source base addresses, a destination base and a length, it streams element-wise results `dst[i] = f(a[i], b[i])` through the RAM's single port. When idle, it transparently forwards CPU accesses to the RAM.

## Interface
Parameters:
- `AW`, 8: address width; RAM depth is 2^AW.
- `DW`, 8: data width.

Ports:
- `clk`  in  1  system clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  launch request; sampled only in IDLE.
- `op`  in  2  operation: 00 ADD, 01 SUB (a−b), 10 AND, 11 COPY (a).
- `src_a`  in  AW  base address of operand A.
- `src_b`  in  AW  base address of operand B.
- `dst`  in  AW  base address of the result vector.
- `len`  in  AW  element count; 0 is legal.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at completion.
- `cpu_mem_enable`  in  1  CPU write enable, forwarded when idle.
- `cpu_adress`  in  AW  CPU address, forwarded when idle.
- `cpu_din`  in  DW  CPU write data, forwarded when idle.
- `mem_enable`  out  1  RAM write enable.
- `adress`  out  AW  RAM address.
- `din`  out  DW  RAM write data.
- `dout_ram`  in  DW  RAM combinational read data, valid in the same cycle as `adress`.

## Operation
- States: IDLE, RD_A, RD_B, WR, DONE.
- On `start` in IDLE, the engine captures `op`, `src_a`, `src_b`, `dst` and `len`, and clears index `i`.
  - `len` = 0: go to DONE.
  - Otherwise: go to RD_A.
- RD_A:
  - `adress` = src_a+i; latch `dout_ram` into `opa`.
  - Next state: RD_B.
- RD_B:
  - `adress` = src_b+i; latch `res` = f(`opa`, `dout_ram`).
  - Next state: WR.
- WR:
  - `adress` = dst+i, `din` = `res`, `mem_enable` = 1.
  - `i`++.
  - Next state: RD_A if `i`+1 < len, else DONE.
- DONE:
  - `done` = 1.
  - Next state: IDLE.
- IDLE: the RAM outputs equal the `cpu_*` inputs combinationally.
- Arithmetic:
  - All results are modulo 2^DW; no carry or borrow is reported.
  - Address sums are modulo 2^AW, so they wrap 0xFF→0x00.
- Ordering: each element is fully written before the next element is read. In-place operation (dst = src_a or dst = src_b) is therefore correct. Overlap with a shifted window follows this strict ascending order.
- `start` outside IDLE is ignored. Inputs may change freely after the launch cycle.
- CPU inputs are ignored while busy, and CPU writes are dropped. The CPU must not write to the RAM while `busy` is high.

## Timing
- Reset values:
  - State IDLE; `busy`, `done` = 0.
  - `opa`, `res`, `i` and all captured registers = 0.
  - RAM outputs follow `cpu_*` (IDLE mux).
- Busy duration:
  - `len` = N > 0: `busy` rises the cycle after `start` and stays high for 3N+1 cycles.
  - `done` coincides with the last busy cycle.
- `len` = 0: `busy` and `done` are both high for exactly one cycle, the cycle after `start`.
- Back-to-back: `start` sampled in the cycle after DONE launches the next job.
- Reset mid-operation:
  - The engine returns to IDLE immediately; `mem_enable` deasserts asynchronously.
  - Elements already written remain in RAM. The element in WR at reset assertion is not guaranteed written.

## Structure
- Shared package `cpu_pkg`:
  - op codes `OP_ADD`, `OP_SUB`, `OP_AND`, `OP_COPY`.
  - State encoding for this block.
  - `AW`/`DW` defaults.
- Sub-module `vec_alu` (combinational `opa`, `opb`, `op` → `res`, DW bits), instanced once.
- The FSM, counter and port mux stay in `mem_vec_engine`.
- The bench instances the engine and the RAM together, with the RAM preloaded as: 0x0A..0x0E = 2,3,4,5,6 and 0x80..0x84 = 1,2,3,4,5.

## Test plan
- ADD, src_a=0x0A, src_b=0x80, dst=0x40, len=5 -> RAM 0x40..0x44 = 3,5,7,9,11; `busy` high 16 cycles; `done` pulses once, on the 16th.
- SUB with the same operands, dst=0x50 -> 0x50..0x54 = 1,1,1,1,1. Then SUB with src_a=0x80, src_b=0x0A -> 0xFF ×5 (modulo wrap).
- COPY, src_a=0x0A, dst=0xFE, len=4 -> 0xFE,0xFF,0x00,0x01 = 2,3,4,5 (address wrap); 0x02 untouched.
- In-place ADD, src_a=dst=0x80, src_b=0x80, len=5 -> 0x80..0x84 = 2,4,6,8,10. Also: len=0 -> `done` the next cycle, no RAM write.
- Reset pulled low in the RD_A of element 2 of the first scenario -> 0x40, 0x41 written; 0x42..0x44 stay 0; `busy`=0 immediately. A `start` during busy is ignored.
- Idle pass-through: CPU write 0xAA to 0x10 -> RAM[0x10]=0xAA. A CPU write while busy -> no effect.
